// File: rtl/fc_pkg.sv
// Shared types and constants for the FC node input buffer.
package fc_pkg;

    localparam int INPUT_HEIGHT_DEF = 4;
    localparam int WORD_SIZE_DEF    = 16;

    typedef logic signed [WORD_SIZE_DEF-1:0] word_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } fc_buf_state_e;

    // Width of a counter that must represent 0..height inclusive.
    function automatic int cnt_width(input int height);
        return $clog2(height + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(INPUT_HEIGHT_DEF);

endpackage

// File: rtl/fc_buf_bank.sv
// One vector bank: INPUT_HEIGHT word registers with an indexed write port
// and a flat parallel read (word k at bits [k*WORD_SIZE +: WORD_SIZE]).
module fc_buf_bank
    import fc_pkg::*;
#(
    parameter int INPUT_HEIGHT = INPUT_HEIGHT_DEF,
    parameter int WORD_SIZE    = WORD_SIZE_DEF,
    parameter int CNT_W        = cnt_width(INPUT_HEIGHT)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [CNT_W-1:0]                  wr_idx,
    input  logic [WORD_SIZE-1:0]              wr_data,
    output logic [INPUT_HEIGHT*WORD_SIZE-1:0] rd_data
);

    logic [WORD_SIZE-1:0] mem [INPUT_HEIGHT];

    // Write the addressed word; indices beyond the array are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < INPUT_HEIGHT; k++) begin
                mem[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < INPUT_HEIGHT; k++) begin
                if (wr_idx == CNT_W'(k)) begin
                    mem[k] <= wr_data;
                end
            end
        end
    end

    // Flatten the array onto the parallel read bus.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < INPUT_HEIGHT; k++) begin
            rd_data[k*WORD_SIZE +: WORD_SIZE] = mem[k];
        end
    end

endmodule

// File: rtl/fc_input_buffer.sv
// Serial-to-parallel feeder for one fully-connected node.
// Collects INPUT_HEIGHT words over valid/ready, pulses start_o, then holds
// the vector until done_i. INPUT_HEIGHT must be at least 2.
// Build option FC_BUF_PINGPONG_EN: two banks so the next vector fills while
// the node works on the current one.
//
// state | meaning
// FILL  | no vector in flight; filling bank accepts words
// ISSUE | start_o high for this cycle; vector presented on data_o
// WAIT  | node busy on the presented vector until done_i
module fc_input_buffer
    import fc_pkg::*;
#(
    parameter int INPUT_HEIGHT = INPUT_HEIGHT_DEF,
    parameter int WORD_SIZE    = WORD_SIZE_DEF
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic                                clear_i,
    input  logic [WORD_SIZE-1:0]                data_i,
    input  logic                                valid_i,
    output logic                                ready_o,
    output logic [INPUT_HEIGHT*WORD_SIZE-1:0]   data_o,
    output logic                                start_o,
    input  logic                                done_i,
    output logic                                busy_o,
    output logic [$clog2(INPUT_HEIGHT+1)-1:0]   count_o
);

    localparam int CNT_W = cnt_width(INPUT_HEIGHT);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(INPUT_HEIGHT - 1);

    fc_buf_state_e    state;
    logic [CNT_W-1:0] count;
    logic             wr_en;
    logic             fill_done;

    assign count_o   = count;
    // A word arriving together with clear_i is dropped.
    assign wr_en     = valid_i && ready_o && !clear_i;
    assign fill_done = wr_en && (count == LAST_IDX);

`ifdef FC_BUF_PINGPONG_EN

    logic                              act;
    logic                              pending;
    logic [INPUT_HEIGHT*WORD_SIZE-1:0] rd_a;
    logic [INPUT_HEIGHT*WORD_SIZE-1:0] rd_b;

    // The bank not presented to the node is always the one filling.
    assign ready_o = !pending;
    assign data_o  = act ? rd_b : rd_a;

    fc_buf_bank #(
        .INPUT_HEIGHT (INPUT_HEIGHT),
        .WORD_SIZE    (WORD_SIZE),
        .CNT_W        (CNT_W)
    ) u_bank_a (
        .clk     (clk_i),
        .rst_n   (reset_n_i),
        .wr_en   (wr_en && act),
        .wr_idx  (count),
        .wr_data (data_i),
        .rd_data (rd_a)
    );

    fc_buf_bank #(
        .INPUT_HEIGHT (INPUT_HEIGHT),
        .WORD_SIZE    (WORD_SIZE),
        .CNT_W        (CNT_W)
    ) u_bank_b (
        .clk     (clk_i),
        .rst_n   (reset_n_i),
        .wr_en   (wr_en && !act),
        .wr_idx  (count),
        .wr_data (data_i),
        .rd_data (rd_b)
    );

    // Sequencing with bank swap; a full fill bank waits as pending for done_i.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= FILL;
            count   <= '0;
            act     <= 1'b0;
            pending <= 1'b0;
            start_o <= 1'b0;
            busy_o  <= 1'b0;
        end else if (clear_i) begin
            state   <= FILL;
            count   <= '0;
            pending <= 1'b0;
            start_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            start_o <= 1'b0;
            if (wr_en) begin
                count <= fill_done ? '0 : count + 1'b1;
            end
            case (state)
                FILL: begin
                    if (fill_done) begin
                        act     <= !act;
                        state   <= ISSUE;
                        start_o <= 1'b1;
                        busy_o  <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    if (fill_done) begin
                        pending <= 1'b1;
                    end
                end
                WAIT: begin
                    if (done_i) begin
                        if (pending || fill_done) begin
                            act     <= !act;
                            pending <= 1'b0;
                            state   <= ISSUE;
                            start_o <= 1'b1;
                        end else begin
                            state  <= FILL;
                            busy_o <= 1'b0;
                        end
                    end else if (fill_done) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    state  <= FILL;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

`else

    assign ready_o = (state == FILL);

    fc_buf_bank #(
        .INPUT_HEIGHT (INPUT_HEIGHT),
        .WORD_SIZE    (WORD_SIZE),
        .CNT_W        (CNT_W)
    ) u_bank (
        .clk     (clk_i),
        .rst_n   (reset_n_i),
        .wr_en   (wr_en),
        .wr_idx  (count),
        .wr_data (data_i),
        .rd_data (data_o)
    );

    // Fill, issue one start pulse, then hold until the node reports done.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= FILL;
            count   <= '0;
            start_o <= 1'b0;
            busy_o  <= 1'b0;
        end else if (clear_i) begin
            state   <= FILL;
            count   <= '0;
            start_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            start_o <= 1'b0;
            case (state)
                FILL: begin
                    if (wr_en) begin
                        if (fill_done) begin
                            count   <= '0;
                            state   <= ISSUE;
                            start_o <= 1'b1;
                            busy_o  <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (done_i) begin
                        state  <= FILL;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= FILL;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_fc_input_buffer.sv
// Scoreboard bench for fc_input_buffer (single-bank build).
module tb_fc_input_buffer;
    import fc_pkg::*;

    localparam int H  = 4;
    localparam int W  = 16;
    localparam int CW = $clog2(H + 1);
    localparam int VW = H * W;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear   = 1'b0;
    logic          valid   = 1'b0;
    logic          done    = 1'b0;
    logic [W-1:0]  din     = '0;
    logic          ready;
    logic          start;
    logic          busy;
    logic [VW-1:0] dout;
    logic [CW-1:0] count;

    fc_input_buffer #(.INPUT_HEIGHT(H), .WORD_SIZE(W)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .clear_i   (clear),
        .data_i    (din),
        .valid_i   (valid),
        .ready_o   (ready),
        .data_o    (dout),
        .start_o   (start),
        .done_i    (done),
        .busy_o    (busy),
        .count_o   (count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: register image, words collected so far, busy/start flags.
    word_t         m_regs [H];
    word_t         m_acc [$];
    bit            m_busy  = 1'b0;
    bit            m_start = 1'b0;
    logic [VW-1:0] exp_q [$];

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] pack_regs();
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < H; k++) v[k*W +: W] = m_regs[k];
        return v;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < H; k++) m_regs[k] = '0;
        m_acc.delete();
        exp_q.delete();
        m_busy  = 1'b0;
        m_start = 1'b0;
    endfunction

    // Apply the transfer/start/done rules for one rising edge.
    function automatic void model_edge();
        bit was_start;
        was_start = m_start;
        m_start   = 1'b0;
        if (clear) begin
            m_acc.delete();
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (valid) begin
                m_regs[m_acc.size()] = word_t'(din);
                m_acc.push_back(word_t'(din));
                if (m_acc.size() == H) begin
                    exp_q.push_back(pack_regs());
                    m_acc.delete();
                    m_busy  = 1'b1;
                    m_start = 1'b1;
                end
            end
        end else if (!was_start && done) begin
            m_busy = 1'b0;
        end
    endfunction

    task automatic check_outputs();
        check("ready", VW'(ready), VW'(!m_busy));
        check("busy",  VW'(busy),  VW'(m_busy));
        check("start", VW'(start), VW'(m_start));
        check("count", VW'(count), VW'(m_acc.size()));
        check("data",  dout,       pack_regs());
    endtask

    task automatic step(input bit v, input logic [W-1:0] d, input bit dn, input bit clr);
        valid = v;
        din   = d;
        done  = dn;
        clear = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b0, 1'b0);
    endtask

    // Monitor: every start pulse must present the next expected vector.
    always @(negedge clk) begin
        if (reset_n && start === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_start", VW'(start), '0);
            else                   check("vector", dout, exp_q.pop_front());
        end
    end

    logic [W-1:0] gap_words [4];
    bit           gap_valid [7];

    initial begin
        int wi;
        model_reset();
        #12;
        check("rst_ready", VW'(ready), VW'(1));
        check("rst_start", VW'(start), '0);
        check("rst_busy",  VW'(busy),  '0);
        check("rst_count", VW'(count), '0);
        check("rst_data",  dout,       '0);
        @(negedge clk);
        reset_n = 1'b1;

        // Back-to-back 1..4, then hold done low with valid high.
        for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
        check("vec_1234", dout, 64'h0004_0003_0002_0001);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(1);

        // Gappy valid pattern packs the same as a contiguous stream.
        gap_words = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
        gap_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        wi = 0;
        for (int i = 0; i < 7; i++) begin
            if (gap_valid[i]) begin
                step(1'b1, gap_words[wi], 1'b0, 1'b0);
                wi++;
            end else begin
                step(1'b0, W'($urandom), 1'b0, 1'b0);
            end
        end
        idle(2);
        check("vec_gappy", dout, 64'h000D_000C_000B_000A);
        step(1'b0, '0, 1'b1, 1'b0);

        // Partial vector aborted by clear (coinciding word is dropped).
        step(1'b1, W'($urandom), 1'b0, 1'b0);
        step(1'b1, W'($urandom), 1'b0, 1'b0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, W'(16'h10 + i), 1'b0, 1'b0);
        idle(1);
        check("vec_clear", dout, 64'h0013_0012_0011_0010);
        step(1'b0, '0, 1'b1, 1'b0);

        // Randomised traffic including done during start and random clears.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 70, W'($urandom),
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3);
        end

        // Drain to FILL, then reach WAIT and drop reset between edges.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
        idle(2);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_ready", VW'(ready), VW'(1));
        check("arst_start", VW'(start), '0);
        check("arst_busy",  VW'(busy),  '0);
        check("arst_count", VW'(count), '0);
        check("arst_data",  dout,       '0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
        idle(3);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(3);
        check("queue_empty", VW'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
